// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and widths for the ALU operand loader
package alu_pkg;
   localparam int OPCODE_W = 4;
   localparam int DATA_W   = 32;

   typedef enum logic [1:0] {
      WAIT_A  = 2'd0,
      WAIT_B  = 2'd1,
      WAIT_OP = 2'd2,
      DONE    = 2'd3
   } loader_state_t;
endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser, debounce counter and rising-edge press pulse
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          db;
   logic          db_d;
   logic [CW-1:0] cnt;

   // press is registered off db/db_d so it lands DEBOUNCE_CYCLES+2 cycles after the raw edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         db    <= 1'b0;
         db_d  <= 1'b0;
         press <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         db_d  <= db;
         press <= db & ~db_d;
         if (sync2 == db) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            db  <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign level = db;
endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - button-driven sequencer capturing SW into operands and opcode
module alu_operand_loader
   import alu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                btn_a,
   input  logic                btn_b,
   input  logic                btn_f,
   input  logic [DATA_W-1:0]   SW,
   output logic [DATA_W-1:0]   a_q,
   output logic [DATA_W-1:0]   b_q,
   output logic [OPCODE_W-1:0] op_q,
   output logic                exec,
   output logic [1:0]          stage
);
   logic press_a;
   logic press_b;
   logic press_f;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
      .clk(clk), .rst(rst), .btn_raw(btn_a), .level(), .press(press_a)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
      .clk(clk), .rst(rst), .btn_raw(btn_b), .level(), .press(press_b)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_f (
      .clk(clk), .rst(rst), .btn_raw(btn_f), .level(), .press(press_f)
   );

   loader_state_t state;
   loader_state_t state_next;
   logic          load_a;
   logic          load_b;
   logic          load_op;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= WAIT_A;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         exec  <= 1'b0;
      end else begin
         state <= state_next;
         exec  <= load_op;
         if (load_a)  a_q  <= SW;
         if (load_b)  b_q  <= SW;
         if (load_op) op_q <= SW[OPCODE_W-1:0];
      end
   end

   // Only presses valid in the current state compete; A beats B beats F
   always_comb begin
      state_next = state;
      load_a     = 1'b0;
      load_b     = 1'b0;
      load_op    = 1'b0;
      case (state)
         WAIT_A: begin
            if (press_a) begin
               load_a     = 1'b1;
               state_next = WAIT_B;
            end
         end
         WAIT_B: begin
            if (press_b) begin
               load_b     = 1'b1;
               state_next = WAIT_OP;
            end
         end
         WAIT_OP: begin
            if (press_f) begin
               load_op    = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (press_a) begin
               load_a     = 1'b1;
               state_next = WAIT_B;
            end else if (press_b) begin
               load_b     = 1'b1;
               state_next = WAIT_OP;
            end else if (press_f) begin
               load_op    = 1'b1;
            end
         end
         default: state_next = WAIT_A;
      endcase
   end

   assign stage = state;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - directed self-checking bench for alu_operand_loader
module tb_alu_operand_loader;
   logic        clk = 1'b0;
   logic        rst;
   logic        btn_a;
   logic        btn_b;
   logic        btn_f;
   logic [31:0] SW;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [3:0]  op_q;
   logic        exec;
   logic [1:0]  stage;

   int total = 0;
   int bad = 0;
   int exec_cnt = 0;

   alu_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b), .btn_f(btn_f),
      .SW(SW), .a_q(a_q), .b_q(b_q), .op_q(op_q), .exec(exec), .stage(stage)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (!rst && exec) exec_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] eo, input logic [31:0] es);
      check({tag, ".a_q"}, a_q, ea);
      check({tag, ".b_q"}, b_q, eb);
      check({tag, ".op_q"}, {28'd0, op_q}, eo);
      check({tag, ".stage"}, {30'd0, stage}, es);
   endtask

   initial begin
      rst = 1'b1; btn_a = 1'b0; btn_b = 1'b0; btn_f = 1'b0; SW = '0;
      tick(3);
      check_all("reset", 32'h0, 32'h0, 32'h0, 32'h0);
      check("reset.exec", {31'd0, exec}, 32'h0);
      rst = 1'b0;
      tick(2);

      // full sequence with exact capture latency
      SW = 32'h0000_0007; btn_a = 1'b1;
      tick(7);
      check("a_early", a_q, 32'h0);
      tick(1);
      check("a_cap", a_q, 32'h7);
      check("a_stage", {30'd0, stage}, 32'd1);
      btn_a = 1'b0; tick(10);

      SW = 32'hFFFF_FFF9; btn_b = 1'b1;
      tick(7);
      check("b_early", b_q, 32'h0);
      tick(1);
      check("b_cap", b_q, 32'hFFFF_FFF9);
      check("b_stage", {30'd0, stage}, 32'd2);
      btn_b = 1'b0; tick(10);

      SW = 32'h0000_0002; btn_f = 1'b1;
      tick(7);
      check("f_exec_early", {31'd0, exec}, 32'h0);
      tick(1);
      check("f_exec", {31'd0, exec}, 32'h1);
      check_all("full", 32'h7, 32'hFFFF_FFF9, 32'h2, 32'h3);
      tick(1);
      check("f_exec_once", {31'd0, exec}, 32'h0);
      btn_f = 1'b0; tick(10);
      check("full.exec_cnt", exec_cnt, 32'd1);

      // simultaneous presses in DONE: only A wins
      SW = 32'h55; btn_a = 1'b1; btn_b = 1'b1; btn_f = 1'b1;
      tick(8);
      check_all("simul", 32'h55, 32'hFFFF_FFF9, 32'h2, 32'h1);
      btn_a = 1'b0; btn_b = 1'b0; btn_f = 1'b0; tick(10);
      check("simul.stage_hold", {30'd0, stage}, 32'd1);
      check("simul.exec_cnt", exec_cnt, 32'd1);

      SW = 32'hFFFF_FFF9; btn_b = 1'b1; tick(8); btn_b = 1'b0; tick(10);
      SW = 32'h2; btn_f = 1'b1; tick(8); btn_f = 1'b0; tick(10);
      check_all("back_done", 32'h55, 32'hFFFF_FFF9, 32'h2, 32'h3);

      // re-execute in DONE with a new opcode
      SW = 32'h3; btn_f = 1'b1; tick(8);
      check("reexec.exec", {31'd0, exec}, 32'h1);
      btn_f = 1'b0; tick(10);
      check_all("reexec", 32'h55, 32'hFFFF_FFF9, 32'h3, 32'h3);
      check("reexec.exec_cnt", exec_cnt, 32'd3);

      rst = 1'b1; tick(1); rst = 1'b0;
      check_all("rst2", 32'h0, 32'h0, 32'h0, 32'h0);

      // out-of-order presses in WAIT_A are ignored
      SW = 32'hABCD; btn_f = 1'b1; tick(8); btn_f = 1'b0; tick(10);
      btn_b = 1'b1; tick(8); btn_b = 1'b0; tick(10);
      check_all("ooo", 32'h0, 32'h0, 32'h0, 32'h0);
      check("ooo.exec_cnt", exec_cnt, 32'd3);

      // bounce shorter than the debounce window
      SW = 32'h1234;
      begin
         logic [4:0] pat;
         pat = 5'b01101;
         for (int i = 0; i < 5; i++) begin
            btn_a = pat[i];
            tick(1);
            check("bounce.stage", {30'd0, stage}, 32'd0);
         end
      end
      btn_a = 1'b1;
      tick(7);
      check("bounce.early", a_q, 32'h0);
      tick(1);
      check_all("bounce", 32'h1234, 32'h0, 32'h0, 32'h1);
      tick(20);
      check("bounce.held", {30'd0, stage}, 32'd1);
      btn_a = 1'b0; tick(10);

      // reset while btn_b is mid-debounce in WAIT_B
      SW = 32'h999; btn_b = 1'b1;
      tick(4);
      rst = 1'b1; tick(1);
      check_all("mid_rst", 32'h0, 32'h0, 32'h0, 32'h0);
      rst = 1'b0;
      tick(20);
      check_all("post_rst", 32'h0, 32'h0, 32'h0, 32'h0);
      btn_b = 1'b0; tick(10);
      check("final.exec_cnt", exec_cnt, 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Front-end stage for the switch-driven ALU board design. Synchronises and debounces the three raw operand pushbuttons (A, B, F) and runs a sequencer FSM that captures SW into operand A, operand B and opcode in order. Presents registered operands plus a one-cycle `exec` strobe to the downstream ALU/display stage, so operand capture no longer clocks registers directly from button signals.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a button change is accepted; 10 ms at 100 MHz, must be ≥ 2.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_a`  in  1  raw, asynchronous, bouncy button for loading A.
- `btn_b`  in  1  raw button for loading B.
- `btn_f`  in  1  raw button for loading the opcode and executing.
- `SW`  in  32  switch bank; captured value source.
- `a_q`  out  32  captured operand A.
- `b_q`  out  32  captured operand B.
- `op_q`  out  4  captured opcode, `SW[3:0]`.
- `exec`  out  1  one-cycle strobe: `a_q`/`b_q`/`op_q` form a new valid ALU request.
- `stage`  out  2  FSM state code for LED indication.

## Operation
- **Per-button input path:**
  - Two-flop synchroniser feeds a debouncer.
  - The debouncer keeps a debounced level `db`, reset 0, and a counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If the synced level equals `db`, `cnt` is cleared to 0.
  - Otherwise `cnt` increments. When `cnt` reaches `DEBOUNCE_CYCLES-1`, `db` takes the synced value and `cnt` is cleared.
  - `press` is a single-cycle pulse on the 0→1 transition of `db`. Releases produce no pulse.
- **FSM** (`stage` code shown in brackets):
  - WAIT_A [0]: `press_a` → `a_q`←SW; go to WAIT_B.
  - WAIT_B [1]: `press_b` → `b_q`←SW; go to WAIT_OP.
  - WAIT_OP [2]: `press_f` → `op_q`←`SW[3:0]`, `exec`=1; go to DONE.
  - DONE [3]:
    - `press_a` → `a_q`←SW; go to WAIT_B.
    - `press_b` → `b_q`←SW; go to WAIT_OP.
    - `press_f` → `op_q`←`SW[3:0]`, `exec`=1; stay in DONE (re-execute with the new opcode).
- A press that is not listed for the current state is ignored. Captured registers do not change, and there is no queuing.
- Simultaneous presses in one cycle: priority A > B > F among the presses valid in the current state. The others are dropped.
- SW is sampled on the same edge that the state transition occurs. SW is not synchronised; the switches are quasi-static.

## Timing
- **Reset values:** `a_q`=0, `b_q`=0, `op_q`=0, `exec`=0, `stage`=0 (WAIT_A). Synchroniser flops, `db` and `cnt` are all 0.
- **Press latency:** let T0 be the first edge at which the raw button is sampled 1, with the button then held. Then `press` is high in cycle T0+`DEBOUNCE_CYCLES`+2 and for one cycle only.
- **Capture latency:** capture registers, `stage` and `exec` update on the edge after `press` is high, i.e. one cycle after `press`. `exec` is high for exactly one cycle. `exec` never asserts in consecutive cycles, because each press takes ≥ `DEBOUNCE_CYCLES` cycles.
- **Bounce filtering:**
  - A bounce shorter than `DEBOUNCE_CYCLES` cycles restarts the count and produces no press.
  - A button held for N presses' worth of time yields exactly one press.
  - The button must be released (debounced 0) and pressed again before another press is produced.
- **Reset mid-operation:** everything returns to its reset value at the next edge while `rst` is high. A button held through reset deassertion is treated as a fresh press: `press` fires `DEBOUNCE_CYCLES`+2 cycles after the first post-reset edge.
- **Counter wrap:** cannot occur, because the counter clears at threshold.

## Structure
- Shared package `alu_pkg`:
  - `loader_state_t` enum with WAIT_A=0, WAIT_B=1, WAIT_OP=2, DONE=3.
  - `OPCODE_W`=4.
  - `DATA_W`=32.
- Sub-module `key_debounce`, instantiated 3×:
  - Ports: `clk`, `rst`, `btn_raw`, `level`, `press`.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Contains the synchroniser, counter and edge detect.
- The top level holds the FSM and the capture registers only.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Full sequence:** reset, then sequential clean presses: `btn_a` with SW=0x0000_0007; `btn_b` with SW=0xFFFF_FFF9; `btn_f` with SW=0x0000_0002.
  - `a_q`=0x7, `b_q`=0xFFFF_FFF9, `op_q`=2.
  - `exec` pulses once, `stage` ends at 3.
  - Each capture lands exactly 7 cycles after raw rises.
- **Bounce:** `btn_a` toggles 1,0,1,1,0 (cycles), then held high.
  - Exactly one capture of A.
  - No capture during the toggling.
- **Out-of-order:** `btn_f` and then `btn_b` pressed in WAIT_A.
  - `stage` stays 0, all outputs stay 0, `exec` never asserts.
- **Simultaneous presses:** in DONE, `btn_a`, `btn_b` and `btn_f` rise on the same cycle with SW=0x55.
  - Only A is captured (`a_q`=0x55), `stage`=1.
  - `b_q` and `op_q` are unchanged, no `exec`.
- **Re-execute:** in DONE, `btn_f` with SW=0x3.
  - `op_q`=3, one `exec` pulse, `stage` stays 3.
  - `a_q`/`b_q` unchanged.
- **Reset mid-debounce:** assert `rst` for 1 cycle while `btn_b` is held in WAIT_B with `cnt`=2.
  - All outputs return to 0.
  - The held button then causes no capture, since it is `btn_b` in WAIT_A.
